// File: rtl/muldiv_seq.sv
// muldiv_seq: iterative multiply/divide unit owning HI/LO (MULT, MULTU, DIV, DIVU, MTHI, MTLO).
// Works on operand magnitudes, one result bit per cycle, and applies the sign fix-up at the end.
module muldiv_seq #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 5
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             cancel,
    input  logic             hi_we,
    input  logic             lo_we,
    input  logic [WIDTH-1:0] wdata,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);
    typedef enum logic [2:0] {IDLE, PREP, CALC, FIX, DONE} state_t;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

    state_t             state, state_nxt;
    logic [1:0]         op_r;
    logic [WIDTH-1:0]   a_r, b_r, opnd;
    logic [2*WIDTH-1:0] acc;
    logic [CNT_W-1:0]   cnt;
    logic               neg_q, neg_r;

    logic               is_div, is_signed;
    logic [WIDTH-1:0]   a_mag, b_mag;
    logic [WIDTH:0]     add_sum, trial;
    logic [2*WIDTH:0]   shifted;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quo_fix, rem_fix;

    assign is_div    = op_r[1];
    assign is_signed = ~op_r[0];
    assign busy      = (state == PREP) || (state == CALC) || (state == FIX);
    assign done      = (state == DONE);

    always_comb begin
        a_mag = a_r;
        b_mag = b_r;
        if (is_signed && a_r[WIDTH-1]) a_mag = -a_r;
        if (is_signed && b_r[WIDTH-1]) b_mag = -b_r;
    end

    // Low half of acc holds the multiplier (shifted out LSB first) or the dividend (MSB first).
    always_comb begin
        add_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opnd} : '0);
        shifted  = {acc, 1'b0};
        trial    = shifted[2*WIDTH:WIDTH] - {1'b0, opnd};
        prod_fix = neg_q ? -acc : acc;
        quo_fix  = neg_q ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
        rem_fix  = neg_r ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = PREP;
            PREP:    state_nxt = cancel ? IDLE : CALC;
            CALC:    if (cancel)           state_nxt = IDLE;
                     else if (cnt == LAST) state_nxt = FIX;
            FIX:     state_nxt = cancel ? IDLE : DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            op_r  <= '0;
            a_r   <= '0;
            b_r   <= '0;
            opnd  <= '0;
            acc   <= '0;
            cnt   <= '0;
            neg_q <= 1'b0;
            neg_r <= 1'b0;
            hi    <= '0;
            lo    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        op_r <= op;
                        a_r  <= A;
                        b_r  <= B;
                    end else begin
                        if (hi_we) hi <= wdata;
                        if (lo_we) lo <= wdata;
                    end
                end
                PREP: begin
                    cnt   <= '0;
                    neg_q <= is_signed & (a_r[WIDTH-1] ^ b_r[WIDTH-1]);
                    neg_r <= is_signed & a_r[WIDTH-1];
                    if (is_div) begin
                        opnd <= b_mag;
                        acc  <= {{WIDTH{1'b0}}, a_mag};
                    end else begin
                        opnd <= a_mag;
                        acc  <= {{WIDTH{1'b0}}, b_mag};
                    end
                end
                CALC: begin
                    if (cnt != LAST) cnt <= cnt + 1'b1;
                    if (!is_div)
                        acc <= {add_sum, acc[WIDTH-1:1]};
                    else if (!trial[WIDTH])
                        acc <= {trial[WIDTH-1:0], shifted[WIDTH-1:1], 1'b1};
                    else
                        acc <= {shifted[2*WIDTH-1:WIDTH], shifted[WIDTH-1:1], 1'b0};
                end
                FIX: begin
                    if (!cancel) begin
                        if (is_div) begin
                            hi <= rem_fix;
                            lo <= quo_fix;
                        end else begin
                            hi <= prod_fix[2*WIDTH-1:WIDTH];
                            lo <= prod_fix[WIDTH-1:0];
                        end
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_muldiv_seq.sv
// tb_muldiv_seq: directed vectors for muldiv_seq with hand-computed HI/LO results.
module tb_muldiv_seq;
    localparam int WIDTH = 32;

    logic             clk = 1'b0;
    logic             rstn;
    logic             start;
    logic [1:0]       opCode;
    logic [WIDTH-1:0] opA;
    logic [WIDTH-1:0] opB;
    logic             cancel;
    logic             hiWe;
    logic             loWe;
    logic [WIDTH-1:0] wdata;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    int vecCount = 0;
    int errCount = 0;

    muldiv_seq #(.WIDTH(WIDTH), .CNT_W(5)) dut (
        .clk(clk), .rstn(rstn), .start(start), .op(opCode), .A(opA), .B(opB),
        .cancel(cancel), .hi_we(hiWe), .lo_we(loWe), .wdata(wdata),
        .busy(busy), .done(done), .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vecCount++;
        if (got !== exp) begin
            errCount++;
            $display("[TB] FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    // Launch one op at a negedge, then count busy cycles until done; optionally pokes
    // start/hi_we mid-CALC, which the unit must ignore.
    task automatic applyStimulus(input string tag, input logic [1:0] opSel,
                                 input logic [31:0] aVal, input logic [31:0] bVal,
                                 input logic [31:0] expHi, input logic [31:0] expLo,
                                 input bit interfere);
        int busyCycles = 0;
        int n = 0;
        @(negedge clk);
        start = 1'b1; opCode = opSel; opA = aVal; opB = bVal;
        @(negedge clk);
        start = 1'b0;
        while (!done && n < 100) begin
            if (busy) busyCycles++;
            if (interfere && n == 5) begin
                start = 1'b1; opCode = 2'b11; opA = 32'd5; opB = 32'd1;
                hiWe = 1'b1; wdata = 32'hDEAD_BEEF;
            end
            if (interfere && n == 6) begin
                start = 1'b0; hiWe = 1'b0;
            end
            n++;
            @(negedge clk);
        end
        checkOutput({tag, "_done_seen"}, 64'(done), 64'd1);
        checkOutput({tag, "_busy_cycles"}, 64'(busyCycles), 64'd34);
        checkOutput({tag, "_busy_at_done"}, 64'(busy), 64'd0);
        checkOutput({tag, "_hilo"}, {hi, lo}, {expHi, expLo});
        @(negedge clk);
        checkOutput({tag, "_done_single"}, 64'(done), 64'd0);
    endtask

    initial begin
        bit doneSeen;
        rstn = 1'b0; start = 1'b0; opCode = 2'b00; opA = '0; opB = '0;
        cancel = 1'b0; hiWe = 1'b0; loWe = 1'b0; wdata = '0;
        #12;
        checkOutput("reset_busy", 64'(busy), 64'd0);
        checkOutput("reset_done", 64'(done), 64'd0);
        checkOutput("reset_hilo", {hi, lo}, 64'd0);
        @(negedge clk);
        rstn = 1'b1;

        applyStimulus("multu_max", 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0);
        applyStimulus("mult_neg",  2'b00, 32'hFFFF_FFFD, 32'd7,         32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0);
        applyStimulus("div_neg",   2'b10, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0);
        applyStimulus("divu",      2'b11, 32'd100,       32'd7,         32'd2,         32'd14,         1'b0);
        applyStimulus("divu_zero", 2'b11, 32'h1234_5678, 32'd0,         32'h1234_5678, 32'hFFFF_FFFF, 1'b0);
        applyStimulus("div_ovf",   2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         32'h8000_0000, 1'b0);

        // MTHI then MTLO preload, then cancel an in-flight MULT at CALC count 10.
        @(negedge clk);
        hiWe = 1'b1; wdata = 32'hAAAA_0000;
        @(negedge clk);
        hiWe = 1'b0; loWe = 1'b1; wdata = 32'h0000_5555;
        @(negedge clk);
        loWe = 1'b0;
        checkOutput("mt_preload", {hi, lo}, {32'hAAAA_0000, 32'h0000_5555});
        start = 1'b1; opCode = 2'b00; opA = 32'd3; opB = 32'd5;
        @(negedge clk);
        start = 1'b0;
        doneSeen = 1'b0;
        repeat (11) begin
            @(negedge clk);
            doneSeen |= done;
        end
        checkOutput("cancel_busy_before", 64'(busy), 64'd1);
        cancel = 1'b1;
        @(negedge clk);
        cancel = 1'b0;
        doneSeen |= done;
        checkOutput("cancel_busy_drop", 64'(busy), 64'd0);
        @(negedge clk);
        doneSeen |= done;
        checkOutput("cancel_busy_after", 64'(busy), 64'd0);
        repeat (30) begin
            @(negedge clk);
            doneSeen |= done;
        end
        checkOutput("cancel_no_done", 64'(doneSeen), 64'd0);
        checkOutput("cancel_hilo_kept", {hi, lo}, {32'hAAAA_0000, 32'h0000_5555});

        applyStimulus("multu_interfere", 2'b01, 32'h0001_0000, 32'h0001_0001, 32'h0000_0001, 32'h0001_0000, 1'b1);

        // Asynchronous reset in the middle of CALC.
        @(negedge clk);
        start = 1'b1; opCode = 2'b00; opA = 32'd9; opB = 32'd9;
        @(negedge clk);
        start = 1'b0;
        repeat (10) @(negedge clk);
        checkOutput("rst_mid_busy_before", 64'(busy), 64'd1);
        rstn = 1'b0;
        #1;
        checkOutput("rst_mid_busy", 64'(busy), 64'd0);
        checkOutput("rst_mid_hilo", {hi, lo}, 64'd0);
        @(negedge clk);
        rstn = 1'b1;
        applyStimulus("multu_after_rst", 2'b01, 32'd6, 32'd7, 32'd0, 32'd42, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vecCount, errCount);
        $finish;
    end
endmodule
